// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of an external PWM pin
// in prescaled ticks, with single/continuous modes and a tick-based timeout.
//
// state     | meaning
// IDLE      | disarmed; arms next cycle if mode is single or continuous
// WAIT_RISE | armed, waiting for a rising edge to open a window
// HIGH      | window open, pin high: period and high-time counting
// LOW       | window open, pin low: period counting, next rise captures
// DONE      | single capture finished, results held until a mode change
module pwm_capture #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] prescalor,
    input  logic [WIDTH-1:0] timeout,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             cap_valid,
    output logic             cap_int,
    output logic             timeout_flag,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RISE = 3'd1,
        HIGH      = 3'd2,
        LOW       = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                 state;
    logic [1:0]             prev_mode;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_d;
    logic [WIDTH-1:0]       cnt_pres;
    logic [WIDTH-1:0]       per_cnt;
    logic [WIDTH-1:0]       hi_cnt;

    logic             sync;
    logic             rise;
    logic             fall;
    logic             tick;
    logic             mode_change;
    logic             armed_mode;
    logic             timeout_hit;
    logic [WIDTH-1:0] restart_pres;
    logic [WIDTH-1:0] restart_cnt;
    logic [WIDTH-1:0] per_inc;
    logic [WIDTH-1:0] hi_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
            sync_d  <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync        = sync_ff[SYNC_STAGES-1];
    assign rise        = sync & ~sync_d;
    assign fall        = ~sync & sync_d;
    assign tick        = (cnt_pres == prescalor);
    assign mode_change = (control != prev_mode);
    assign armed_mode  = (control == 2'b01) || (control == 2'b10);

    // The rise cycle is the first clock of a new window, so with no
    // prescaling it already contributes one tick.
    assign restart_pres = (prescalor == '0) ? '0 : WIDTH'(1);
    assign restart_cnt  = (prescalor == '0) ? WIDTH'(1) : '0;

    assign per_inc     = (tick && per_cnt != '1) ? per_cnt + 1'b1 : per_cnt;
    assign hi_inc      = (tick && hi_cnt != '1) ? hi_cnt + 1'b1 : hi_cnt;
    assign timeout_hit = (timeout != '0) && tick && ((per_cnt + 1'b1) == timeout);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prev_mode    <= 2'b00;
            cnt_pres     <= '0;
            per_cnt      <= '0;
            hi_cnt       <= '0;
            period       <= '0;
            high_time    <= '0;
            cap_valid    <= 1'b0;
            cap_int      <= 1'b0;
            timeout_flag <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cap_int  <= 1'b0;
            cnt_pres <= tick ? '0 : cnt_pres + 1'b1;
            if (mode_change) begin
                prev_mode    <= control;
                state        <= IDLE;
                busy         <= 1'b0;
                cnt_pres     <= '0;
                per_cnt      <= '0;
                hi_cnt       <= '0;
                period       <= '0;
                high_time    <= '0;
                cap_valid    <= 1'b0;
                timeout_flag <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed_mode) begin
                            state <= WAIT_RISE;
                            busy  <= 1'b1;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            state    <= HIGH;
                            cnt_pres <= restart_pres;
                            per_cnt  <= restart_cnt;
                            hi_cnt   <= restart_cnt;
                        end
                    end
                    HIGH: begin
                        if (timeout_hit) begin
                            state        <= WAIT_RISE;
                            timeout_flag <= 1'b1;
                            cap_int      <= 1'b1;
                        end else if (fall) begin
                            per_cnt <= per_inc;
                            state   <= LOW;
                        end else begin
                            per_cnt <= per_inc;
                            hi_cnt  <= hi_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            period    <= per_cnt;
                            high_time <= hi_cnt;
                            cap_valid <= 1'b1;
                            cap_int   <= 1'b1;
                            if (control == 2'b10) begin
                                state    <= HIGH;
                                cnt_pres <= restart_pres;
                                per_cnt  <= restart_cnt;
                                hi_cnt   <= restart_cnt;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end else if (timeout_hit) begin
                            state        <= WAIT_RISE;
                            timeout_flag <= 1'b1;
                            cap_int      <= 1'b1;
                        end else begin
                            per_cnt <= per_inc;
                        end
                    end
                    DONE: begin
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: per-window expectations are computed from
// pulse durations and queued; a negedge monitor checks each cap_int event.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  control;
    logic [31:0] prescalor;
    logic [31:0] timeout;
    logic        pwm_in;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        cap_valid;
    logic        cap_int;
    logic        timeout_flag;
    logic        busy;

    pwm_capture #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .control      (control),
        .prescalor    (prescalor),
        .timeout      (timeout),
        .pwm_in       (pwm_in),
        .period       (period),
        .high_time    (high_time),
        .cap_valid    (cap_valid),
        .cap_int      (cap_int),
        .timeout_flag (timeout_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_to;
        logic [31:0] per;
        logic [31:0] hi;
        logic        valid;
        logic        flag;
    } exp_t;

    exp_t exp_q[$];
    int   hq[$];
    int   lq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_int = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_int = 1'b0;
        end else begin
            if (cap_int) begin
                chk("cap_int_gap", {31'd0, prev_int}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_cap_int", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(e.is_to ? "to_period" : "cap_period", period, e.per);
                    chk(e.is_to ? "to_high_time" : "cap_high_time", high_time, e.hi);
                    chk("cap_valid", {31'd0, cap_valid}, {31'd0, e.valid});
                    chk("timeout_flag", {31'd0, timeout_flag}, {31'd0, e.flag});
                end
            end
            prev_int = cap_int;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each pulse (h, l) is one window: it closes with a capture of
    // floor(clocks/(p+1)) ticks unless timeout*(p+1) clocks elapse first.
    task automatic model(input logic [1:0] ctl, input logic [31:0] p, input logic [31:0] t);
        longint div;
        longint w;
        logic [31:0] lp;
        logic [31:0] lh;
        logic v;
        logic f;
        exp_t e;
        div = longint'(p) + 1;
        lp = '0; lh = '0; v = 1'b0; f = 1'b0;
        for (int i = 0; i < hq.size(); i++) begin
            w = longint'(hq[i]) + longint'(lq[i]);
            if (t != 0 && longint'(t) * div <= w) begin
                f = 1'b1;
                e.is_to = 1'b1; e.per = lp; e.hi = lh; e.valid = v; e.flag = f;
                exp_q.push_back(e);
            end else begin
                lp = 32'(w / div);
                lh = 32'(longint'(hq[i]) / div);
                v = 1'b1;
                e.is_to = 1'b0; e.per = lp; e.hi = lh; e.valid = v; e.flag = f;
                exp_q.push_back(e);
                if (ctl == 2'b01) break;
            end
        end
    endtask

    task automatic drive_run(input logic [1:0] ctl, input logic [31:0] p, input logic [31:0] t);
        prescalor = p;
        timeout   = t;
        control   = ctl;
        model(ctl, p, t);
        step(4);
        for (int i = 0; i < hq.size(); i++) begin
            pwm_in = 1'b1;
            step(hq[i]);
            pwm_in = 1'b0;
            step(lq[i]);
        end
    endtask

    task automatic end_run();
        pwm_in = 1'b1;
        step(8);
        control = 2'b00;
        pwm_in  = 1'b0;
        step(6);
    endtask

    task automatic set_pulses(input int h, input int l, input int n);
        hq.delete();
        lq.delete();
        for (int i = 0; i < n; i++) begin
            hq.push_back(h);
            lq.push_back(l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; control = 2'b00; prescalor = '0; timeout = '0; pwm_in = 1'b0;
        step(5);
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_cap_valid", {31'd0, cap_valid}, 0);
        chk("rst_cap_int", {31'd0, cap_int}, 0);
        chk("rst_timeout_flag", {31'd0, timeout_flag}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b0;
        step(3);

        // Continuous 30/70, then prescaled by 5.
        set_pulses(30, 70, 4);
        drive_run(2'b10, 32'd0, 32'd0);
        end_run();
        drive_run(2'b10, 32'd4, 32'd0);
        end_run();

        // Single capture, hold, clear, re-arm.
        set_pulses(30, 70, 3);
        drive_run(2'b01, 32'd0, 32'd0);
        chk("single_busy", {31'd0, busy}, 0);
        chk("single_period_held", period, 100);
        chk("single_high_held", high_time, 30);
        end_run();
        chk("off_period", period, 0);
        chk("off_cap_valid", {31'd0, cap_valid}, 0);
        set_pulses(30, 70, 1);
        drive_run(2'b01, 32'd0, 32'd0);
        end_run();

        // Timeouts: bare, and after a valid capture.
        set_pulses(200, 10, 1);
        drive_run(2'b10, 32'd0, 32'd50);
        chk("to_flag_sticky", {31'd0, timeout_flag}, 1);
        chk("to_busy_wait_rise", {31'd0, busy}, 1);
        end_run();
        hq.delete(); lq.delete();
        hq.push_back(30); lq.push_back(70);
        hq.push_back(200); lq.push_back(10);
        drive_run(2'b10, 32'd0, 32'd150);
        end_run();

        // Abort mid-HIGH by mode change, then re-arm in single mode.
        set_pulses(30, 70, 1);
        drive_run(2'b10, 32'd0, 32'd0);
        pwm_in = 1'b1;
        step(12);
        control = 2'b01;
        step(1);
        chk("abort_period", period, 0);
        chk("abort_high_time", high_time, 0);
        chk("abort_cap_valid", {31'd0, cap_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        pwm_in = 1'b0;
        step(6);
        chk("rearm_busy", {31'd0, busy}, 1);
        hq.delete(); lq.delete();
        drive_run(2'b01, 32'd0, 32'd0);
        set_pulses(25, 35, 1);
        model(2'b01, 32'd0, 32'd0);
        pwm_in = 1'b1; step(25);
        pwm_in = 1'b0; step(35);
        end_run();

        // Async reset in the middle of LOW.
        set_pulses(30, 70, 1);
        drive_run(2'b10, 32'd0, 32'd0);
        pwm_in = 1'b1; step(20);
        pwm_in = 1'b0; step(10);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_period", period, 0);
        chk("areset_high_time", high_time, 0);
        chk("areset_cap_valid", {31'd0, cap_valid}, 0);
        chk("areset_busy", {31'd0, busy}, 0);
        control = 2'b00;
        step(2);
        reset = 1'b0;
        step(4);

        // Minimum pulses and a prescaler that never ticks.
        set_pulses(1, 1, 3);
        drive_run(2'b10, 32'd0, 32'd0);
        end_run();
        set_pulses(40, 40, 1);
        drive_run(2'b01, 32'hFFFF_FFFF, 32'd0);
        end_run();

        // Randomised runs.
        for (int r = 0; r < 6; r++) begin
            logic [1:0]  ctl;
            logic [31:0] p;
            logic [31:0] t;
            int n;
            ctl = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            p   = $urandom_range(0, 3);
            t   = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(12, 120));
            n   = $urandom_range(3, 8);
            hq.delete(); lq.delete();
            for (int i = 0; i < n; i++) begin
                hq.push_back($urandom_range(1, 40));
                lq.push_back($urandom_range(1, 40));
            end
            drive_run(ctl, p, t);
            end_run();
        end

        chk("events_left", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Input-capture companion to the timer/PWM generator: measures the period and high time of an external PWM signal instead of producing one.
- Counts in prescaled ticks, using the same control, prescalor and max-count style as the generator.
- Sits beside the timer block on the peripheral bus. Raises a one-cycle capture interrupt per completed measurement and per timeout.

Parameters:
WIDTH, 32, width of prescalor, timeout and all measurement counters/outputs
SYNC_STAGES, 2, flip-flop stages synchronizing pwm_in (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
control  input  2  mode: 00 off, 01 single capture, 10 continuous capture, 11 treated as off
prescalor  input  WIDTH  tick divider; one tick every prescalor+1 clocks
timeout  input  WIDTH  max ticks per measurement window; 0 disables timeout
pwm_in  input  1  asynchronous PWM input pin
period  output  WIDTH  last captured period in ticks
high_time  output  WIDTH  last captured high time in ticks
cap_valid  output  1  high once period/high_time hold a valid capture
cap_int  output  1  one-cycle pulse on capture or timeout
timeout_flag  output  1  sticky: a timeout occurred
busy  output  1  high in WAIT_RISE, HIGH, LOW

Behaviour:
- Reset (async): all outputs 0, state IDLE, prev_mode 00, all counters 0.
- Input conditioning
  - pwm_in passes through SYNC_STAGES flops, then one edge-detect flop.
  - rise = sync & ~sync_d; fall = ~sync & sync_d.
  - Pin-to-edge latency: SYNC_STAGES+1 clocks.
- Tick generation
  - tick = (cnt_pres == prescalor).
  - cnt_pres <= tick ? 0 : cnt_pres+1.
- Mode change (control != prev_mode) has the highest priority:
  - that cycle: state→IDLE; counters, cap_valid, timeout_flag, period and high_time cleared; cap_int 0; prev_mode<=control.
  - Mode change mid-measurement aborts it silently (no cap_int).
- States:
  - IDLE: busy 0. Next cycle, mode 01/10 → WAIT_RISE.
  - WAIT_RISE: no counting. On rise → HIGH and restart window.
  - Window restart (rise cycle counts as the first cycle of the window):
    - cnt_pres <= (prescalor==0) ? 0 : 1
    - per_cnt <= (prescalor==0) ? 1 : 0
    - hi_cnt <= same as per_cnt
  - HIGH: per_cnt and hi_cnt += tick. On fall: per_cnt += tick, hi_cnt unchanged, → LOW.
  - LOW: per_cnt += tick.
  - Rise in LOW (capture):
    - period <= per_cnt and high_time <= hi_cnt, excluding the rise cycle.
    - cap_valid <= 1; cap_int pulses the next cycle for 1 clock.
    - Mode 10: the same rise restarts the window, → HIGH (no gap, no missed period).
    - Mode 01: → DONE.
  - DONE: busy 0, outputs held. Leaves only via a mode change; 01→00→01 re-arms.
- Timeout (HIGH or LOW, timeout != 0, tick, per_cnt+1 == timeout):
  - timeout_flag <= 1; cap_int pulse; period/high_time/cap_valid unchanged; → WAIT_RISE.
  - timeout_flag is cleared only by reset or mode change.
- Priority in one cycle: mode change > capture/restart edge > timeout > tick increment.
- Counters saturate at all-ones and never wrap. Results equal floor(clocks/(prescalor+1)).
- cap_int is never high two consecutive cycles from a single event.
- Glitches shorter than one clock may be missed; no filtering.

Test Plan:
1. Basic continuous capture:
   - Stimulus: reset 5 cycles, then control=10, prescalor=0, timeout=0; pwm_in 30 clk high / 70 clk low, repeated.
   - Response: after the 2nd rise, period=100, high_time=30, cap_valid=1, cap_int one pulse per period thereafter.
2. Prescaled capture:
   - Stimulus: same waveform, prescalor=4.
   - Response: period=20, high_time=6 on every capture.
3. Single mode:
   - Stimulus: control=01 with the waveform running.
   - Response: exactly one cap_int, values 100/30, busy→0 and held.
   - Then control=00, then 01: cleared to 0, then a fresh capture.
4. Timeout:
   - Stimulus: control=10, prescalor=0, timeout=50; one rise, then pwm_in held high.
   - Response: timeout_flag=1 and cap_int pulse when per_cnt hits 50; period/high_time keep previous values; state WAIT_RISE.
5. Abort and reset mid-operation:
   - Mode change 10→01 during HIGH: no cap_int, all outputs 0, re-arms.
   - Async reset asserted mid-LOW: all outputs 0 immediately.
6. Edge cases:
   - 1 clk high / 1 clk low (after synchronizer) at prescalor=0: period=2, high_time=1.
   - prescalor=all-ones with a long pulse: counters stay 0, no wrap.
